// File: rtl/tabela_sweep_ctrl.sv
// tabela_sweep_ctrl: walks every input row of two N_IN-input boolean functions,
// captures both truth tables and reports equivalence, mismatch count and the
// lowest differing row. Abort cancels a sweep but keeps the partial results.
module tabela_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_a,
    input  logic                   f_b,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [(1<<N_IN)-1:0]   table_a,
    output logic [(1<<N_IN)-1:0]   table_b,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_mis,
    output logic                   first_valid,
    output logic                   equal
);

    localparam int ROWS  = 1 << N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Value of the settle counter on the last WAIT cycle of a row.
    localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE
    } state_t;

    // With no settle time a new row is sampled straight away.
    localparam state_t ROW_ENTRY = (SETTLE > 0) ? S_WAIT : S_SAMPLE;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [ROWS-1:0]   tbl_a_q, tbl_a_d;
    logic [ROWS-1:0]   tbl_b_q, tbl_b_d;
    logic [N_IN:0]     mis_cnt_q, mis_cnt_d;
    logic [N_IN-1:0]   first_mis_q, first_mis_d;
    logic              first_valid_q, first_valid_d;
    logic              equal_q, equal_d;

    logic              row_mis;
    logic [N_IN:0]     mis_cnt_inc;

    assign row_mis     = f_a ^ f_b;
    assign mis_cnt_inc = mis_cnt_q + {{N_IN{1'b0}}, row_mis};

    // Next-state and result update for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        vec_d         = vec_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = aborted_q;
        tbl_a_d       = tbl_a_q;
        tbl_b_d       = tbl_b_q;
        mis_cnt_d     = mis_cnt_q;
        first_mis_d   = first_mis_q;
        first_valid_d = first_valid_q;
        equal_d       = equal_q;

        case (state_q)
            S_IDLE: begin
                // start together with abort is treated as no request at all
                if (start && !abort) begin
                    vec_d         = '0;
                    cnt_d         = '0;
                    tbl_a_d       = '0;
                    tbl_b_d       = '0;
                    mis_cnt_d     = '0;
                    first_valid_d = 1'b0;
                    equal_d       = 1'b0;
                    aborted_d     = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = ROW_ENTRY;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                // abort suppresses the capture of the current row
                if (abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    tbl_a_d[vec_q] = f_a;
                    tbl_b_d[vec_q] = f_b;
                    mis_cnt_d      = mis_cnt_inc;
                    if (row_mis && !first_valid_q) begin
                        first_mis_d   = vec_q;
                        first_valid_d = 1'b1;
                    end
                    if (vec_q == '1) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        equal_d = (mis_cnt_inc == '0);
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = '0;
                        state_d = ROW_ENTRY;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            vec_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            tbl_a_q       <= '0;
            tbl_b_q       <= '0;
            mis_cnt_q     <= '0;
            first_mis_q   <= '0;
            first_valid_q <= 1'b0;
            equal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            vec_q         <= vec_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            tbl_a_q       <= tbl_a_d;
            tbl_b_q       <= tbl_b_d;
            mis_cnt_q     <= mis_cnt_d;
            first_mis_q   <= first_mis_d;
            first_valid_q <= first_valid_d;
            equal_q       <= equal_d;
        end
    end

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign table_a      = tbl_a_q;
    assign table_b      = tbl_b_q;
    assign mismatch_cnt = mis_cnt_q;
    assign first_mis    = first_mis_q;
    assign first_valid  = first_valid_q;
    assign equal        = equal_q;

endmodule

// File: tb/tb_tabela_sweep_ctrl.sv
// Bench for tabela_sweep_ctrl: a default instance (SETTLE=1) driven through
// several function pairs, abort and reset cases, plus a SETTLE=0 instance.
module tb_tabela_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic [2:0] vec_out;
    logic       f_a, f_b;
    logic       busy, done, aborted;
    logic [7:0] table_a, table_b;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_mis;
    logic       first_valid, equal;
    int         mode;

    logic       start0, abort0;
    logic [2:0] vec0;
    logic       fa0, fb0;
    logic       busy0, done0, aborted0;
    logic [7:0] ta0, tb0;
    logic [3:0] cnt0;
    logic [2:0] fm0;
    logic       fv0, eq0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] ta;
        logic [7:0] tb;
        logic [3:0] cnt;
        logic [2:0] fm;
        logic       fv;
        logic       eq;
    } exp_t;

    exp_t sb_q[$];

    tabela_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vec_out(vec_out), .f_a(f_a), .f_b(f_b),
        .busy(busy), .done(done), .aborted(aborted),
        .table_a(table_a), .table_b(table_b),
        .mismatch_cnt(mismatch_cnt), .first_mis(first_mis),
        .first_valid(first_valid), .equal(equal)
    );

    tabela_sweep_ctrl #(.N_IN(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .vec_out(vec0), .f_a(fa0), .f_b(fb0),
        .busy(busy0), .done(done0), .aborted(aborted0),
        .table_a(ta0), .table_b(tb0),
        .mismatch_cnt(cnt0), .first_mis(fm0),
        .first_valid(fv0), .equal(eq0)
    );

    // reference expression (x|~y|~z)&(~x|y|~z)&(~x|y|z)
    function automatic logic fa_fn(input logic [2:0] v);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        return (x | ~y | ~z) & (~x | y | ~z) & (~x | y | z);
    endfunction

    // 0: simplified equivalent, 1: stuck at 0, 2: row 5 flipped
    function automatic logic fb_fn(input int md, input logic [2:0] v);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        case (md)
            0:       return (~x | y) & (x | ~y | ~z);
            1:       return 1'b0;
            default: return fa_fn(v) ^ (v == 3'd5);
        endcase
    endfunction

    function automatic exp_t model(input int md);
        exp_t e;
        logic a, b;
        e = '0;
        for (int r = 0; r < 8; r++) begin
            a = fa_fn(3'(r));
            b = fb_fn(md, 3'(r));
            e.ta[r] = a;
            e.tb[r] = b;
            if (a != b) begin
                if (!e.fv) begin
                    e.fm = 3'(r);
                    e.fv = 1'b1;
                end
                e.cnt = e.cnt + 4'd1;
            end
        end
        e.eq = (e.cnt == 4'd0);
        return e;
    endfunction

    assign f_a = fa_fn(vec_out);
    assign f_b = fb_fn(mode, vec_out);
    assign fa0 = fa_fn(vec0);
    assign fb0 = fb_fn(0, vec0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_sweep(input int md, input bit mid_start);
        exp_t e;
        int   busy_n;
        bit   got;
        mode = md;
        sb_q.push_back(model(md));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy_n = busy ? 1 : 0;
        got    = 1'b0;
        for (int k = 1; k <= 64 && !got; k++) begin
            start = (mid_start && k == 4);
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                chk("done_latency", 64'(k), 64'd16);
                chk("busy_after_done", 64'(busy), 64'd0);
                if (sb_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("table_a", 64'(table_a), 64'(e.ta));
                    chk("table_b", 64'(table_b), 64'(e.tb));
                    chk("mismatch_cnt", 64'(mismatch_cnt), 64'(e.cnt));
                    chk("first_valid", 64'(first_valid), 64'(e.fv));
                    chk("equal", 64'(equal), 64'(e.eq));
                    if (e.fv) chk("first_mis", 64'(first_mis), 64'(e.fm));
                end
            end else if (busy) begin
                busy_n++;
            end
        end
        start = 1'b0;
        if (!got) chk("done_seen", 64'd0, 64'd1);
        chk("busy_cycles", 64'(busy_n), 64'd16);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("result_hold", 64'(table_a), 64'(fa_tbl()));
    endtask

    function automatic logic [7:0] fa_tbl();
        logic [7:0] t;
        for (int r = 0; r < 8; r++) t[r] = fa_fn(3'(r));
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        int busy_n;
        bit got;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        mode   = 0;
        #12;
        chk("reset_all_zero",
            64'({vec_out, table_a, table_b, mismatch_cnt, first_mis, first_valid, equal, done, busy, aborted}),
            64'd0);
        rst_n = 1'b1;

        // equivalent pair
        run_sweep(0, 1'b0);
        chk("equiv_table_a", 64'(table_a), 64'hC7);
        chk("equiv_table_b", 64'(table_b), 64'hC7);

        // stuck-at-0 B
        run_sweep(1, 1'b0);
        chk("stuck_cnt", 64'(mismatch_cnt), 64'd5);

        // single-row fault with a start pulse mid-sweep
        run_sweep(2, 1'b1);
        chk("row5_table_b", 64'(table_b), 64'hE7);
        chk("row5_first_mis", 64'(first_mis), 64'd5);

        // abort during the SAMPLE of row 2
        mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_flag", 64'(aborted), 64'd1);
        chk("abort_table_a", 64'(table_a), 64'h03);
        chk("abort_cnt", 64'(mismatch_cnt), 64'd2);
        chk("abort_first", 64'({first_valid, first_mis}), 64'h8);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_equal", 64'(equal), 64'd0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("both_busy", 64'(busy), 64'd0);
        chk("both_aborted", 64'(aborted), 64'd1);
        repeat (2) @(posedge clk);
        #1 chk("both_idle", 64'(busy), 64'd0);

        run_sweep(0, 1'b0);
        chk("aborted_cleared", 64'(aborted), 64'd0);

        // reset in the middle of a sweep
        mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midreset_zero",
               64'({vec_out, table_a, table_b, mismatch_cnt, first_mis, first_valid, equal, done, busy, aborted}),
               64'd0);
        #3 rst_n = 1'b1;
        run_sweep(0, 1'b0);

        // zero settle instance
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        busy_n = busy0 ? 1 : 0;
        got    = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                got = 1'b1;
                chk("zs_done_latency", 64'(k), 64'd8);
            end else if (busy0) begin
                busy_n++;
            end
        end
        if (!got) chk("zs_done_seen", 64'd0, 64'd1);
        chk("zs_busy_cycles", 64'(busy_n), 64'd8);
        chk("zs_table_a", 64'(ta0), 64'hC7);
        chk("zs_table_b", 64'(tb0), 64'hC7);
        chk("zs_equal", 64'({eq0, cnt0}), 64'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tabela_sweep_ctrl.md
# tabela_sweep_ctrl

Sequencer that exhaustively sweeps the input space of two N-input combinational boolean functions, typically an unsimplified expression and its simplified form. It drives a shared input vector into both function units, waits a settle time, samples both outputs, and builds both truth tables. It also reports whether the two functions are equivalent, how many rows differ, and the lowest differing row. It is the on-chip counterpart of the truth-table testbench tasks and sits between a start/done host and the function-under-test pair.

## Interface
- `N_IN`, default 3: number of function inputs; the sweep covers 2^N_IN rows.
- `SETTLE`, default 1: wait cycles between driving a vector and sampling; 0 is legal.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: begin a sweep; honoured only in IDLE.
- `abort`  in  1: cancel a sweep in progress.
- `vec_out`  out  N_IN: input vector to both functions. MSB is the first variable (x), LSB is the last (z).
- `f_a`  in  1: output of function A (reference expression).
- `f_b`  in  1: output of function B (simplified expression).
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: one-cycle pulse when a sweep completes normally.
- `aborted`  out  1: high after an aborted sweep; cleared by the next start.
- `table_a`  out  2^N_IN: truth table of A; bit i holds f_a at vec_out == i.
- `table_b`  out  2^N_IN: truth table of B; same layout as `table_a`.
- `mismatch_cnt`  out  N_IN+1: number of rows where f_a != f_b.
- `first_mis`  out  N_IN: lowest row index with a mismatch.
- `first_valid`  out  1: high if `first_mis` holds a real mismatch.
- `equal`  out  1: high when mismatch_cnt == 0 and the last sweep completed normally.

## Operation
- States: IDLE, WAIT, SAMPLE.
- Reset (async, `rst_n` = 0):
  - state = IDLE.
  - All outputs are 0, including `vec_out`, `table_a`, `table_b`, `mismatch_cnt`, `first_mis`, `first_valid`, `equal`, `done`, `busy` and `aborted`.
- IDLE, `start` = 1 and `abort` = 0:
  - `vec_out` <= 0.
  - Tables, `mismatch_cnt`, `first_valid`, `equal` and `aborted` clear.
  - `busy` <= 1.
  - Next state is WAIT if SETTLE > 0, otherwise SAMPLE.
- WAIT: a settle counter runs for exactly SETTLE cycles, then the state moves to SAMPLE. `vec_out` is stable throughout.
- SAMPLE, in one cycle:
  - table_a[vec_out] <= f_a and table_b[vec_out] <= f_b.
  - On f_a != f_b, `mismatch_cnt` increments. If `first_valid` = 0, `first_mis` <= vec_out and `first_valid` <= 1.
  - Row not last: `vec_out` increments and the state returns to WAIT (or SAMPLE if SETTLE = 0).
  - Row last (all ones): the state goes to IDLE, `busy` <= 0, `done` <= 1 for one cycle, and `equal` <= (final count == 0), counting the current row's mismatch.
- Rows are swept in ascending order 0 … 2^N_IN−1. `vec_out` never wraps within a sweep.
- Abort, `abort` = 1 in WAIT or SAMPLE:
  - Next state is IDLE, `busy` <= 0, `aborted` <= 1.
  - No `done` pulse; `equal` stays 0.
  - Partial tables and counts are retained. The SAMPLE-cycle capture is suppressed, so abort wins.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: no sweep begins and `aborted` is unchanged.
- Results hold after `done` until the next accepted start or reset.
- `mismatch_cnt` width N_IN+1 holds the full 2^N_IN without overflow.

## Timing
- Each row takes SETTLE+1 cycles.
- Start edge E: final sample at edge E + 2^N_IN·(SETTLE+1); `done` is high in the cycle after it.
- Defaults (N_IN = 3, SETTLE = 1): 16 busy cycles, and `done` is observed at E+16.
- f_a and f_b are sampled at the rising edge that ends SAMPLE, at least SETTLE+1 edges after `vec_out` changed.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Equivalent pair:
  - Stimulus: f_a = (x|~y|~z)&(~x|y|~z)&(~x|y|z) and f_b = (~x|y)&(x|~y|~z) on `vec_out`, defaults.
  - Response: table_a = table_b = 8'hC7, mismatch_cnt = 0, equal = 1, first_valid = 0, `done` at E+16.
- Stuck output:
  - Stimulus: f_a as above, f_b tied 0.
  - Response: table_b = 8'h00, mismatch_cnt = 5, first_mis = 0, first_valid = 1, equal = 0.
- Single-row fault:
  - Stimulus: f_b = f_a XOR (vec_out == 5).
  - Response: mismatch_cnt = 1, first_mis = 5, table_b = 8'hE7.
- Zero settle:
  - Stimulus: SETTLE = 0 with the equivalent pair.
  - Response: `done` at E+8; `busy` high for 8 cycles.
- Abort, busy start and simultaneous events:
  - Abort asserted at E+5 → busy = 0 at E+6, aborted = 1, no `done` pulse.
  - `start` pulsed mid-sweep → ignored; `done` still at E+16.
  - `start` and `abort` together in IDLE → stays IDLE.
- Reset mid-sweep: rst_n = 0 at E+7 → all outputs 0 immediately; the next start runs a clean full sweep.
